bullet_pool_controller: RTL

Owns a fixed pool of player bullet slots. Spawns bullets at the player sprite on the fire button, moves them upward on a shared movement tick, and retires them when they leave the top of the screen or a collision clears them. Sits beside the player sprite controller and feeds the bullet renderer and the collision checker.

---
 rtl/game_pkg.sv | 28 ++
 rtl/move_tick_gen.sv | 29 ++
 rtl/bullet_pool_controller.sv | 134 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared screen, sprite and bullet geometry for the game pipeline, plus the
// helpers that place a new bullet relative to the player sprite.
package game_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned SPRITE_W = 32;
  localparam int unsigned SPRITE_H = 32;
  localparam int unsigned BULLET_W = 4;
  localparam int unsigned BULLET_H = 8;
  localparam int unsigned COORD_W  = 10;

  // Centred on the sprite; computed one bit wider so a sprite near the right
  // edge clamps instead of wrapping.
  function automatic logic [COORD_W-1:0] spawn_x(input logic [COORD_W-1:0] px);
    logic [COORD_W:0] sx;
    sx = {1'b0, px} + (COORD_W+1)'(SPRITE_W / 2 - BULLET_W / 2);
    if (sx > (COORD_W+1)'(SCREEN_W - BULLET_W)) begin
      sx = (COORD_W+1)'(SCREEN_W - BULLET_W);
    end
    return sx[COORD_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] spawn_y(input logic [COORD_W-1:0] py);
    return (py < COORD_W'(BULLET_H)) ? '0 : py - COORD_W'(BULLET_H);
  endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Free-running movement tick: one-cycle pulse every TICK_PERIOD clocks,
// shared by the bullet pool and the player sprite controller.
module move_tick_gen #(
  parameter int unsigned TICK_PERIOD = 131072
) (
  input  logic clk25,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_W'(TICK_PERIOD - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bullet_pool_controller.sv
// Player bullet pool: spawns on fire, moves up each tick, retires on top exit
// or hit. Define BULLET_AUTOFIRE_EN for level-sensitive (held) fire.
module bullet_pool_controller
  import game_pkg::*;
#(
  parameter int unsigned NUM_BULLETS    = 4,
  parameter int unsigned TICK_PERIOD    = 131072,
  parameter int unsigned BULLET_SPEED   = 4,
  parameter int unsigned COOLDOWN_TICKS = 16
) (
  input  logic                             clk25,
  input  logic                             rst,
  input  logic                             btn_fire,
  input  logic [COORD_W-1:0]               player_x,
  input  logic [COORD_W-1:0]               player_y,
  input  logic                             hit_valid,
  input  logic [$clog2(NUM_BULLETS)-1:0]   hit_idx,
  output logic [NUM_BULLETS-1:0]           bullet_active,
  output logic [NUM_BULLETS*COORD_W-1:0]   bullet_x,
  output logic [NUM_BULLETS*COORD_W-1:0]   bullet_y,
  output logic                             fire_pulse
);

  localparam int unsigned IDX_W = $clog2(NUM_BULLETS);
  localparam int unsigned CD_W  = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

  logic                           tick;
  logic                           fire_req;
  logic                           pending_q, pending_d;
  logic [CD_W-1:0]                cooldown_q, cooldown_d;
  logic [NUM_BULLETS-1:0]         active_q, active_d;
  logic [NUM_BULLETS*COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic                           fire_q, fire_d;
  logic                           free_found;
  logic [IDX_W-1:0]               free_idx;
  logic                           spawn;
  logic [31:0]                    hit_sel;

  move_tick_gen #(.TICK_PERIOD(TICK_PERIOD)) u_tick (
    .clk25(clk25),
    .rst  (rst),
    .tick (tick)
  );

`ifdef BULLET_AUTOFIRE_EN
  assign fire_req = btn_fire;
`else
  logic btn_q;

  always_ff @(posedge clk25) begin
    if (rst) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_fire;
    end
  end

  assign fire_req = btn_fire & ~btn_q;
`endif

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
      if (!free_found && !active_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign spawn   = tick && pending_q && (cooldown_q == '0) && free_found;
  assign hit_sel = 32'(hit_idx);

  // Priority per slot: hit beats movement; spawn (only into a pre-tick free
  // slot) overrides last, so a hit on an already-inactive slot cannot block it.
  always_comb begin
    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
      if (hit_valid && hit_sel == i) begin
        active_d[i] = 1'b0;
      end else if (tick && active_q[i]) begin
        if (y_q[i*COORD_W +: COORD_W] < COORD_W'(BULLET_SPEED)) begin
          active_d[i] = 1'b0;
        end else begin
          y_d[i*COORD_W +: COORD_W] = y_q[i*COORD_W +: COORD_W] - COORD_W'(BULLET_SPEED);
        end
      end
      if (spawn && free_idx == IDX_W'(i)) begin
        active_d[i]               = 1'b1;
        x_d[i*COORD_W +: COORD_W] = spawn_x(player_x);
        y_d[i*COORD_W +: COORD_W] = spawn_y(player_y);
      end
    end
  end

  always_comb begin
    cooldown_d = cooldown_q;
    if (tick && cooldown_q != '0) begin
      cooldown_d = cooldown_q - CD_W'(1);
    end
    if (spawn) begin
      cooldown_d = CD_W'(COOLDOWN_TICKS);
    end
    pending_d = (pending_q & ~spawn) | fire_req;
    fire_d    = spawn;
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      pending_q  <= 1'b0;
      cooldown_q <= '0;
      active_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      fire_q     <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      cooldown_q <= cooldown_d;
      active_q   <= active_d;
      x_q        <= x_d;
      y_q        <= y_d;
      fire_q     <= fire_d;
    end
  end

  assign bullet_active = active_q;
  assign bullet_x      = x_q;
  assign bullet_y      = y_q;
  assign fire_pulse    = fire_q;

endmodule
